rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among WIDTH requesters.
- Built around a leftmost-priority one-hot pick: the highest-index set bit of a masked request vector wins.
- A rotating priority mask gives fairness; a grant is held until its requester drops its request.
- Sits in front of shared register-file and bus ports in the xregister fabric.

---
 rtl/rr_onehot_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter built on a leftmost-priority
// (highest-index-wins) one-hot pick behind a rotating priority mask.
// A grant is held until its requester drops its request. The
// registered grant, grant_id and busy outputs all update on the same edge.
//
// Optional feature macro: RR_ARB_HOLD_LIMIT_EN
//   When defined, a hold counter forces a release after MAX_HOLD
//   consecutive grant cycles. The grant then passes to the next winner, or
//   returns to the same owner if nobody else is waiting.
//   When undefined, no counter exists and ownership is unbounded.
//
// Debug visibility: the FSM state is held in state_q (IDLE / OWN).
module rr_onehot_arbiter #(
    parameter int WIDTH    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy
);

    // Elaboration-time parameter sanity checks
    if (WIDTH < 2) begin : g_chk_width
        $error("rr_onehot_arbiter: WIDTH must be >= 2");
    end
    if (ID_W != $clog2(WIDTH)) begin : g_chk_id_w
        $error("rr_onehot_arbiter: ID_W must equal clog2(WIDTH)");
    end
    if (MAX_HOLD < 2) begin : g_chk_max_hold
        $error("rr_onehot_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q, busy_d;

    // Pick datapath
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_masked;
    logic [ID_W-1:0]  idx_masked;
    logic [ID_W-1:0]  idx_any;
    logic [ID_W-1:0]  winner;

    // Control
    logic             owner_req;
    logic             force_rel;
    logic             new_grant;
    logic [ID_W-1:0]  new_idx;

    // The current owner's bit never competes in a re-pick. On a natural
    // release it is already 0. On a forced release it must be ignored.
    // In IDLE, grant_q is zero, so cand is simply req.
    assign owner_req = |(req & grant_q);

    // Pick: highest set bit of the masked candidates, else highest set bit overall
    always_comb begin
        cand        = req & ~grant_q;
        cand_masked = cand & mask_q;
        idx_masked  = '0;
        idx_any     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cand_masked[i]) idx_masked = ID_W'(i);
            if (cand[i])        idx_any    = ID_W'(i);
        end
        winner = (|cand_masked) ? idx_masked : idx_any;
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    assign force_rel = (state_q == ST_OWN) &&
                       (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // Hold counter: clears on every new grant, counts each cycle the grant is kept
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant) begin
            hold_cnt_d = '0;
        end else if (state_q == ST_OWN && state_d == ST_OWN) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    // Hold counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // Next-state logic: grant on request from IDLE, re-pick on release in OWN
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        mask_d     = mask_q;
        new_grant  = 1'b0;
        new_idx    = winner;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                end
            end
            ST_OWN: begin
                if (!owner_req || force_rel) begin
                    if (|cand) begin
                        new_grant = 1'b1;
                    end else if (owner_req) begin
                        // Forced release with no one else waiting: same owner again
                        new_grant = 1'b1;
                        new_idx   = grant_id_q;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
            end
        endcase

        // Every new grant to index i leaves only indices below i in the mask.
        // Index 0 wraps the mask back to all ones.
        if (new_grant) begin
            state_d    = ST_OWN;
            busy_d     = 1'b1;
            grant_id_d = new_idx;
            for (int i = 0; i < WIDTH; i++) begin
                grant_d[i] = (new_idx == ID_W'(i));
                mask_d[i]  = (new_idx == '0) || (ID_W'(i) < new_idx);
            end
        end
    end

    // State, grant and mask registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            mask_q     <= '1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            mask_q     <= mask_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter. A reference model tracks the owner index
// and the last granted index, then picks the winner using the
// round-robin rule. Expected outputs go through exp_q and are compared
// on the falling edge.
module tb_rr_onehot_arbiter;
  localparam int WIDTH    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 4;
  localparam int EW       = WIDTH + ID_W + 2;
`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Expected word: {check_id, busy, grant_id, grant}
  logic [EW-1:0] exp_q[$];

  // Reference model state
  int m_owner    = -1;     // -1 = no grant
  int m_last     = WIDTH;  // indices below m_last get priority
  int m_cnt      = 0;      // cycles the current owner has held past its first
  bit m_rst_edge = 1'b0;

  rr_onehot_arbiter #(
    .WIDTH   (WIDTH),
    .ID_W    (ID_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [WIDTH-1:0] r, input int last);
    for (int j = last - 1; j >= 0; j--) if (r[j]) return j;
    for (int j = WIDTH - 1; j >= 0; j--) if (r[j]) return j;
    return -1;
  endfunction

  function automatic void grant_to(input int i);
    m_owner = i;
    m_last  = (i == 0) ? WIDTH : i;
    m_cnt   = 0;
  endfunction

  always @(posedge clk) begin
    logic [WIDTH-1:0] others;
    logic [WIDTH-1:0] eg;
    logic [EW-1:0]    e;
    bit               forced;
    if (rst) begin
      m_owner    = -1;
      m_last     = WIDTH;
      m_cnt      = 0;
      m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      if (m_owner < 0) begin
        if (req != '0) grant_to(pick(req, m_last));
      end else begin
        forced = HOLD_EN && (m_cnt == MAX_HOLD - 1) && req[m_owner];
        if (!req[m_owner] || forced) begin
          others = req;
          others[m_owner] = 1'b0;
          if (others != '0) grant_to(pick(others, m_last));
          else if (forced)  grant_to(m_owner);
          else              m_owner = -1;
        end else begin
          m_cnt++;
        end
      end
    end
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    e = {(m_owner >= 0) || m_rst_edge,
         (m_owner >= 0),
         (m_owner >= 0) ? ID_W'(m_owner) : ID_W'(0),
         eg};
    exp_q.push_back(e);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", 32'(grant), 32'(e[WIDTH-1:0]));
      check("busy", 32'(busy), 32'(e[WIDTH+ID_W]));
      if (e[EW-1]) check("grant_id", 32'(grant_id), 32'(e[WIDTH+ID_W-1:WIDTH]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [WIDTH-1:0] q, input int n);
    rst = r;
    req = q;
    repeat (n) @(negedge clk);
  endtask

  task automatic rotate(input int rounds);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < rounds; k++) begin
      drive(1'b0, 4'b1111, 2);
      d = 4'b1111;
      if (m_owner >= 0) d[m_owner] = 1'b0;
      drive(1'b0, d, 1);
    end
  endtask

  task automatic random_run(input int n);
    logic [WIDTH-1:0] cur;
    logic             r;
    cur = '0;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(3) == 0) cur[b] = ~cur[b];
      r = ($urandom_range(63) == 0);
      drive(r, cur, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    // reset held with all requests asserted, then first grant
    drive(1'b1, 4'b1111, 2);
    drive(1'b0, 4'b1111, 1);
    drive(1'b0, 4'b0000, 2);
    // priority and release without bubble
    drive(1'b0, 4'b1010, 2);
    drive(1'b0, 4'b0010, 2);
    drive(1'b0, 4'b0000, 2);
    // rotation from a fresh mask
    drive(1'b1, 4'b0000, 1);
    rotate(5);
    // wrap and sole requester
    drive(1'b0, 4'b0001, 2);
    drive(1'b0, 4'b0000, 1);
    drive(1'b0, 4'b1001, 2);
    drive(1'b0, 4'b0000, 1);
    drive(1'b0, 4'b1000, 2);
    drive(1'b0, 4'b0000, 1);
    // reset in the middle of a grant
    drive(1'b1, 4'b0000, 1);
    drive(1'b0, 4'b0100, 2);
    drive(1'b1, 4'b0100, 1);
    drive(1'b0, 4'b0101, 2);
    drive(1'b0, 4'b0000, 1);
    // long steady contention and a lone requester
    drive(1'b1, 4'b0000, 1);
    drive(1'b0, 4'b1100, 14);
    drive(1'b0, 4'b0100, 10);
    drive(1'b0, 4'b0000, 2);
    // randomized traffic
    random_run(3000);
    drive(1'b0, 4'b0000, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
